// File: rtl/dbus_arbiter.sv
// Two-master AHB-Lite data-bus arbiter: combinational address grant, data phase steered by the registered owner.
// No added latency; a denied owner's completion waits in a one-entry buffer and is returned on its next grant.
module dbus_arbiter (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic [31:0] s_m0_haddr_i,
  input  logic [31:0] s_m0_hwdata_i,
  input  logic [2:0]  s_m0_hsize_i,
  input  logic [1:0]  s_m0_htrans_i,
  input  logic        s_m0_hwrite_i,
  input  logic [5:0]  s_m0_hparity_i,
  input  logic [6:0]  s_m0_hwdcheck_i,
  input  logic        s_m0_hmastlock_i,
  output logic        s_m0_hready_o,
  output logic        s_m0_hresp_o,
  output logic [31:0] s_m0_hrdata_o,
  output logic [6:0]  s_m0_hrdcheck_o,
  input  logic [31:0] s_m1_haddr_i,
  input  logic [31:0] s_m1_hwdata_i,
  input  logic [2:0]  s_m1_hsize_i,
  input  logic [1:0]  s_m1_htrans_i,
  input  logic        s_m1_hwrite_i,
  input  logic [5:0]  s_m1_hparity_i,
  input  logic [6:0]  s_m1_hwdcheck_i,
  output logic        s_m1_hready_o,
  output logic        s_m1_hresp_o,
  output logic [31:0] s_m1_hrdata_o,
  output logic [6:0]  s_m1_hrdcheck_o,
  output logic [31:0] s_haddr_o,
  output logic [31:0] s_hwdata_o,
  output logic [2:0]  s_hsize_o,
  output logic [1:0]  s_htrans_o,
  output logic        s_hwrite_o,
  output logic [5:0]  s_hparity_o,
  output logic [6:0]  s_hwdcheck_o,
  input  logic        s_hready_i,
  input  logic        s_hresp_i,
  input  logic [31:0] s_hrdata_i,
  input  logic [6:0]  s_hrdcheck_i
);
  typedef struct packed {
    logic [31:0] rdata;
    logic [6:0]  rdcheck;
    logic        resp;
  } rsp_t;

  logic [1:0] req;
  logic       gnt_vld;
  logic       gnt_id;
  logic [1:0] gnt_oh;
  logic       grant_r_vld;
  logic       grant_r_id;
  logic       hold_r;
  logic       lock_r;
  logic       last_r;
  logic       dp_vld;
  logic       dp_id;
  logic [1:0] dp_oh;
  logic [1:0] pend;
  logic [1:0] cap;
  logic [1:0] hready_v;
  rsp_t       bus_rsp;
  rsp_t [1:0] rsp_buf;
  rsp_t [1:0] view;

  assign req     = {s_m1_htrans_i[1], s_m0_htrans_i[1]};
  assign bus_rsp = {s_hrdata_i, s_hrdcheck_i, s_hresp_i};

  // Reset forces no grant so the bus goes IDLE at once rather than at the next edge.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!s_reset_i) begin
      if (hold_r) begin
        gnt_vld = grant_r_vld;
        gnt_id  = grant_r_id;
      end else if (lock_r) begin
        gnt_vld = req[0];
      end else if (&req) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_r;
      end else if (|req) begin
        gnt_vld = 1'b1;
        gnt_id  = req[1];
      end
    end
  end

  assign gnt_oh = {gnt_vld & gnt_id, gnt_vld & ~gnt_id};
  assign dp_oh  = {dp_vld & dp_id, dp_vld & ~dp_id};

  always_comb begin
    s_haddr_o   = '0;
    s_hsize_o   = '0;
    s_htrans_o  = '0;
    s_hwrite_o  = 1'b0;
    s_hparity_o = '0;
    if (gnt_oh[0]) begin
      s_haddr_o   = s_m0_haddr_i;
      s_hsize_o   = s_m0_hsize_i;
      s_htrans_o  = s_m0_htrans_i;
      s_hwrite_o  = s_m0_hwrite_i;
      s_hparity_o = s_m0_hparity_i;
    end else if (gnt_oh[1]) begin
      s_haddr_o   = s_m1_haddr_i;
      s_hsize_o   = s_m1_hsize_i;
      s_htrans_o  = s_m1_htrans_i;
      s_hwrite_o  = s_m1_hwrite_i;
      s_hparity_o = s_m1_hparity_i;
    end
  end

  always_comb begin
    s_hwdata_o   = '0;
    s_hwdcheck_o = '0;
    if (dp_oh[0]) begin
      s_hwdata_o   = s_m0_hwdata_i;
      s_hwdcheck_o = s_m0_hwdcheck_i;
    end else if (dp_oh[1]) begin
      s_hwdata_o   = s_m1_hwdata_i;
      s_hwdcheck_o = s_m1_hwdcheck_i;
    end
  end

  // A completing owner that is still requesting but lost the grant must park its response.
  always_comb begin
    hready_v = '0;
    cap      = '0;
    view     = {bus_rsp, bus_rsp};
    for (int n = 0; n < 2; n++) begin
      if (pend[n]) begin
        hready_v[n] = s_hready_i & gnt_oh[n];
        view[n]     = rsp_buf[n];
      end else if (dp_oh[n]) begin
        hready_v[n] = s_hready_i & (gnt_oh[n] | ~req[n]);
        cap[n]      = s_hready_i & req[n] & ~gnt_oh[n];
      end else begin
        hready_v[n]  = ~req[n] | (gnt_oh[n] & s_hready_i);
        view[n].resp = 1'b0;
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      grant_r_vld <= 1'b0;
      grant_r_id  <= 1'b0;
      hold_r      <= 1'b0;
      dp_vld      <= 1'b0;
      dp_id       <= 1'b0;
      lock_r      <= 1'b0;
      last_r      <= 1'b1;
      pend        <= '0;
      rsp_buf     <= '0;
    end else begin
      grant_r_vld <= gnt_vld;
      grant_r_id  <= gnt_id;
      hold_r      <= ~s_hready_i;
      if (s_hready_i) begin
        dp_vld <= gnt_vld;
        dp_id  <= gnt_id;
        if (gnt_vld) last_r <= gnt_id;
        if (gnt_oh[0]) lock_r <= s_m0_hmastlock_i;
        else           lock_r <= 1'b0;
      end
      for (int n = 0; n < 2; n++) begin
        if (cap[n]) begin
          rsp_buf[n] <= bus_rsp;
          pend[n]    <= 1'b1;
        end else if (pend[n] && hready_v[n]) begin
          pend[n] <= 1'b0;
        end
      end
    end
  end

  assign s_m0_hready_o   = hready_v[0];
  assign s_m0_hresp_o    = view[0].resp;
  assign s_m0_hrdata_o   = view[0].rdata;
  assign s_m0_hrdcheck_o = view[0].rdcheck;
  assign s_m1_hready_o   = hready_v[1];
  assign s_m1_hresp_o    = view[1].resp;
  assign s_m1_hrdata_o   = view[1].rdata;
  assign s_m1_hrdcheck_o = view[1].rdcheck;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter: two random masters and a slave with waits and errors, checked
// every cycle against a transaction-level model of grants, data-phase ownership and owed responses.
`timescale 1ns/1ps
module tb_dbus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0][31:0] m_haddr, m_hwdata, m_hrdata;
  logic [1:0][2:0]  m_hsize;
  logic [1:0][1:0]  m_htrans;
  logic [1:0]       m_hwrite, m_hready, m_hresp;
  logic [1:0][5:0]  m_hparity;
  logic [1:0][6:0]  m_hwdcheck, m_hrdcheck;
  logic             m0_lock;
  logic [31:0] b_haddr, b_hwdata, s_hrdata;
  logic [2:0]  b_hsize;
  logic [1:0]  b_htrans;
  logic        b_hwrite, s_hready, s_hresp;
  logic [5:0]  b_hparity;
  logic [6:0]  b_hwdcheck, s_hrdcheck;

  dbus_arbiter dut (
    .s_clk_i(clk), .s_reset_i(rst),
    .s_m0_haddr_i(m_haddr[0]), .s_m0_hwdata_i(m_hwdata[0]), .s_m0_hsize_i(m_hsize[0]),
    .s_m0_htrans_i(m_htrans[0]), .s_m0_hwrite_i(m_hwrite[0]), .s_m0_hparity_i(m_hparity[0]),
    .s_m0_hwdcheck_i(m_hwdcheck[0]), .s_m0_hmastlock_i(m0_lock),
    .s_m0_hready_o(m_hready[0]), .s_m0_hresp_o(m_hresp[0]), .s_m0_hrdata_o(m_hrdata[0]),
    .s_m0_hrdcheck_o(m_hrdcheck[0]),
    .s_m1_haddr_i(m_haddr[1]), .s_m1_hwdata_i(m_hwdata[1]), .s_m1_hsize_i(m_hsize[1]),
    .s_m1_htrans_i(m_htrans[1]), .s_m1_hwrite_i(m_hwrite[1]), .s_m1_hparity_i(m_hparity[1]),
    .s_m1_hwdcheck_i(m_hwdcheck[1]),
    .s_m1_hready_o(m_hready[1]), .s_m1_hresp_o(m_hresp[1]), .s_m1_hrdata_o(m_hrdata[1]),
    .s_m1_hrdcheck_o(m_hrdcheck[1]),
    .s_haddr_o(b_haddr), .s_hwdata_o(b_hwdata), .s_hsize_o(b_hsize), .s_htrans_o(b_htrans),
    .s_hwrite_o(b_hwrite), .s_hparity_o(b_hparity), .s_hwdcheck_o(b_hwdcheck),
    .s_hready_i(s_hready), .s_hresp_i(s_hresp), .s_hrdata_i(s_hrdata), .s_hrdcheck_i(s_hrdcheck)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: transactions, not registers.
  int          prev_gnt, last_m, dp_m, err_ph;
  bit          stalled, lock_m, dp_v;
  logic [31:0] dp_addr;
  bit   [1:0]  outst, free;
  logic [1:0][31:0] out_addr;
  logic [39:0] rq0[$], rq1[$];

  function automatic logic [31:0] wd(input logic [31:0] a);
    return a ^ 32'hC3A5_5A3C;
  endfunction
  function automatic logic [6:0] wdc(input logic [31:0] a);
    return a[8:2] ^ 7'h2B;
  endfunction

  task automatic model_reset();
    stalled = 1'b0; prev_gnt = 2; lock_m = 1'b0; last_m = 1; dp_v = 1'b0;
    outst = '0; err_ph = 0;
    rq0.delete(); rq1.delete();
  endtask

  task automatic drive_masters(input bit force_both);
    for (int n = 0; n < 2; n++) begin
      if (free[n]) begin
        if (force_both || $urandom_range(99) < 75) m_htrans[n] = $urandom_range(1) ? 2'b10 : 2'b11;
        else                                       m_htrans[n] = $urandom_range(1) ? 2'b00 : 2'b01;
        m_haddr[n]   = ($urandom & 32'h0000_FFFC) | ((n == 1) ? 32'h8000_0000 : 32'h0);
        m_hsize[n]   = 3'($urandom_range(2));
        m_hwrite[n]  = 1'($urandom_range(1));
        m_hparity[n] = 6'($urandom);
        if (n == 0) m0_lock = ($urandom_range(3) == 0);
      end
      m_hwdata[n]   = outst[n] ? wd(out_addr[n])  : $urandom;
      m_hwdcheck[n] = outst[n] ? wdc(out_addr[n]) : 7'($urandom);
    end
  endtask

  task automatic drive_slave();
    int r;
    if (err_ph == 1) begin
      s_hready = 1'b1; s_hresp = 1'b1; err_ph = 0;
    end else if (dp_v) begin
      r = $urandom_range(99);
      if (r < 15)      begin s_hready = 1'b0; s_hresp = 1'b0; end
      else if (r < 25) begin s_hready = 1'b0; s_hresp = 1'b1; err_ph = 1; end
      else             begin s_hready = 1'b1; s_hresp = 1'b0; end
    end else begin
      s_hready = 1'b1; s_hresp = 1'b0;
    end
    s_hrdata   = $urandom;
    s_hrdcheck = 7'($urandom);
  endtask

  task automatic eval();
    int g, gi;
    bit r0, r1, rq, buffered;
    bit [1:0] ehr;
    logic [39:0] ev;
    if (rst) g = 2;
    else if (stalled) g = prev_gnt;
    else begin
      r0 = m_htrans[0][1];
      r1 = m_htrans[1][1] & ~lock_m;
      if (r0 && r1) g = 1 - last_m;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
      else          g = 2;
    end
    gi = (g < 2) ? g : 0;
    chk("bus_haddr",  b_haddr,   (g < 2) ? m_haddr[gi]   : 32'h0);
    chk("bus_htrans", b_htrans,  (g < 2) ? m_htrans[gi]  : 2'h0);
    chk("bus_hsize",  b_hsize,   (g < 2) ? m_hsize[gi]   : 3'h0);
    chk("bus_hwrite", b_hwrite,  (g < 2) ? m_hwrite[gi]  : 1'b0);
    chk("bus_hparity", b_hparity, (g < 2) ? m_hparity[gi] : 6'h0);
    chk("bus_hwdata", b_hwdata,  dp_v ? wd(dp_addr)  : 32'h0);
    chk("bus_hwdcheck", b_hwdcheck, dp_v ? wdc(dp_addr) : 7'h0);

    for (int n = 0; n < 2; n++) begin
      rq = m_htrans[n][1];
      if (rq)             ehr[n] = (g == n) && s_hready;
      else if (!outst[n]) ehr[n] = 1'b1;
      else                ehr[n] = dp_v && (dp_m == n) && s_hready;
      buffered = (n == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
      if (buffered) ev = (n == 0) ? rq0[0] : rq1[0];
      else          ev = {s_hrdata, s_hrdcheck, (dp_v && dp_m == n) ? s_hresp : 1'b0};
      chk($sformatf("m%0d_hready", n), m_hready[n], ehr[n]);
      chk($sformatf("m%0d_hrdata", n), m_hrdata[n], ev[39:8]);
      chk($sformatf("m%0d_hrdcheck", n), m_hrdcheck[n], ev[7:1]);
      chk($sformatf("m%0d_hresp", n), m_hresp[n], ev[0]);
    end

    if (!rst) begin
      if (s_hready && dp_v) begin
        if (dp_m == 0) rq0.push_back({s_hrdata, s_hrdcheck, s_hresp});
        else           rq1.push_back({s_hrdata, s_hrdcheck, s_hresp});
      end
      for (int n = 0; n < 2; n++) begin
        if (ehr[n] && outst[n]) begin
          if (n == 0 && rq0.size() != 0) void'(rq0.pop_front());
          if (n == 1 && rq1.size() != 0) void'(rq1.pop_front());
        end
      end
      if (s_hready) begin
        dp_v = (g < 2);
        if (g < 2) begin
          dp_m = g; dp_addr = m_haddr[gi]; last_m = g;
        end
        lock_m = (g == 0) ? m0_lock : 1'b0;
      end
      stalled  = !s_hready;
      prev_gnt = g;
    end
    for (int n = 0; n < 2; n++) begin
      free[n] = ehr[n];
      if (ehr[n]) begin
        outst[n] = m_htrans[n][1];
        if (m_htrans[n][1]) out_addr[n] = m_haddr[n];
      end
    end
  endtask

  initial begin
    bit did_rst;
    int rel_at, bn;
    rst = 1'b1;
    m_htrans = '0; m_haddr = '0; m_hwdata = '0; m_hsize = '0; m_hwrite = '0;
    m_hparity = '0; m_hwdcheck = '0; m0_lock = 1'b0;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = '0; s_hrdcheck = '0;
    free = 2'b11; out_addr = '0; dp_m = 0; dp_addr = '0;
    model_reset();
    did_rst = 1'b0;
    rel_at = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (rst && cyc == rel_at) rst = 1'b0;
      if (cyc >= 2) drive_masters(cyc == 2);
      drive_slave();
      if (!did_rst && cyc >= 400 && ((rq0.size() + rq1.size()) != 0 || cyc == 1500)) begin
        did_rst = 1'b1;
        bn = (rq1.size() != 0) ? 1 : 0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_htrans_now", b_htrans, 2'h0);
        chk("rst_haddr_now", b_haddr, 32'h0);
        chk("rst_pend_clr", m_hrdata[bn], s_hrdata);
        chk("rst_hresp_now", m_hresp[bn], 1'b0);
        rel_at = cyc + 1;
      end
      @(negedge clk);
      eval();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
